// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// No logic; latency not applicable.
// No flow control here; consumers own the handshake.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } seq_tx_state_t;

    // Start-of-frame marker seen by the downstream "1101" detector
    localparam logic [3:0] SEQ_TX_PREAMBLE = 4'b1101;
    localparam int         SEQ_TX_PRE_LEN  = 4;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register feeding the serial output.
// Load or shift takes effect on the next edge; msb is a register bit.
// No backpressure; the owner gates load_en/shift_en.
module seq_tx_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_dat,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    // Load has priority over shift; zeros are shifted in at the bottom
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load_en) begin
            sr <= load_dat;
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: parallel word in, MSB-first bit stream out, idle gap after each frame.
// Latency: first bit one cycle after accept; optional 1101 preamble (SEQ_PATTERN_TX_PREAMBLE_EN) adds 4 cycles.
// Backpressure: din_ready only in IDLE; din/din_valid ignored while a frame or gap is in progress.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int GCW = $clog2(16);
    // Gap counter runs GAP_CYCLES-1 down to 0, one GAP cycle per count
    localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_tx_state_t  state, state_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [GCW-1:0] gap_cnt, gap_cnt_nxt;
    logic           done_nxt;
    logic           load_en;
    logic           shift_en;
    logic           sh_msb;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    logic [1:0]     pre_cnt, pre_cnt_nxt;
`endif

    seq_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .shift_en (shift_en),
        .load_dat (din),
        .msb      (sh_msb)
    );

    // State, counters and the registered done pulse; reset drops any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            pre_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            done    <= done_nxt;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            pre_cnt <= pre_cnt_nxt;
`endif
        end
    end

    // Next-state, counter updates and outputs, all decoded from registered state
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        done_nxt    = 1'b0;
        load_en     = 1'b0;
        shift_en    = 1'b0;
        dout        = 1'b0;
        dout_valid  = 1'b0;
        busy        = (state != IDLE);
        // Gated by rst so nothing looks acceptable while reset is held
        din_ready   = (state == IDLE) && rst;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
        pre_cnt_nxt = pre_cnt;
`endif

        case (state)
            IDLE: begin
                if (din_valid && din_ready) begin
                    load_en     = 1'b1;
                    bit_cnt_nxt = BCW'(WIDTH);
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
                    pre_cnt_nxt = '0;
                    state_nxt   = PRE;
`else
                    state_nxt   = DATA;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
            PRE: begin
                dout_valid  = 1'b1;
                dout        = SEQ_TX_PREAMBLE[2'd3 - pre_cnt];
                pre_cnt_nxt = pre_cnt + 2'd1;
                if (pre_cnt == 2'(SEQ_TX_PRE_LEN - 1)) begin
                    state_nxt = DATA;
                end
            end
`endif
            DATA: begin
                dout_valid  = 1'b1;
                dout        = sh_msb;
                shift_en    = 1'b1;
                bit_cnt_nxt = bit_cnt - BCW'(1);
                if (bit_cnt == BCW'(1)) begin
                    done_nxt = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GCW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench: u_dut uses the default gap, u_b uses a zero gap for back-to-back frames.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din,   din_b;
    logic       din_valid, din_valid_b;
    logic       din_ready, din_ready_b;
    logic       dout, dout_b;
    logic       dout_valid, dout_valid_b;
    logic       busy, busy_b;
    logic       done, done_b;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
    localparam int PRE_N = 4;
`else
    localparam int PRE_N = 0;
`endif

    seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
    );

    seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word on u_dut and checks every cycle through the gap back to IDLE
    task automatic run_frame(input logic [7:0] word, input bit noise, input string tag);
        logic [11:0] fr;
        int n;
`ifdef SEQ_PATTERN_TX_PREAMBLE_EN
        fr = {4'b1101, word};
`else
        fr = {4'b0000, word};
`endif
        n = 8 + PRE_N;
        chk({tag, ".rdy_pre"}, din_ready, 1);
        din = word;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, ".vld"}, dout_valid, 1);
            chk({tag, ".bit"}, dout, fr[n-1-i]);
            chk({tag, ".done_lo"}, done, 0);
            chk({tag, ".rdy_lo"}, din_ready, 0);
            if (noise) begin
                din = ~word ^ 8'(i);
                din_valid = i[0];
            end
            tick();
        end
        din_valid = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".gap_vld"}, dout_valid, 0);
        chk({tag, ".gap_dout"}, dout, 0);
        chk({tag, ".gap_busy"}, busy, 1);
        chk({tag, ".gap_rdy"}, din_ready, 0);
        tick();
        chk({tag, ".done_once"}, done, 0);
        chk({tag, ".gap2_rdy"}, din_ready, 0);
        tick();
        chk({tag, ".rdy_back"}, din_ready, 1);
        chk({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0;
        din = 8'hA5;
        din_valid = 1'b1;
        din_b = 8'h00;
        din_valid_b = 1'b0;

        // Reset held two cycles with din_valid asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst.rdy", din_ready, 0);
            chk("rst.dout", dout, 0);
            chk("rst.vld", dout_valid, 0);
            chk("rst.busy", busy, 0);
            chk("rst.done", done, 0);
            chk("rst.rdy_b", din_ready_b, 0);
        end
        rst = 1'b1;
        din_valid = 1'b0;
        #1;
        chk("rel.rdy", din_ready, 1);
        chk("rel.busy", busy, 0);
        chk("rel.vld", dout_valid, 0);
        chk("rel.rdy_b", din_ready_b, 1);

        // Single frame A5: bits 1,0,1,0,0,1,0,1
        run_frame(8'hA5, 1'b0, "a5");
        // Preamble build sends 1101 then 0,0,1,1,1,1,0,0
        run_frame(8'h3C, 1'b0, "3c");
        // din/din_valid toggling mid-frame is ignored
        run_frame(8'h96, 1'b1, "noise");

        // Back-to-back on the zero-gap instance: FF then 00
        din_b = 8'hFF;
        din_valid_b = 1'b1;
        tick();
        din_b = 8'h00;
        for (int i = 0; i < 8 + PRE_N; i++) begin
            chk("b2b.vld1", dout_valid_b, 1);
            chk("b2b.bit1", dout_b, (i < PRE_N) ? ((i == 2) ? 0 : 1) : 1);
            chk("b2b.done1_lo", done_b, 0);
            tick();
        end
        chk("b2b.gap_vld", dout_valid_b, 0);
        chk("b2b.done1", done_b, 1);
        chk("b2b.rdy", din_ready_b, 1);
        chk("b2b.busy", busy_b, 0);
        tick();
        din_valid_b = 1'b0;
        for (int i = 0; i < 8 + PRE_N; i++) begin
            chk("b2b.vld2", dout_valid_b, 1);
            chk("b2b.bit2", dout_b, (i < PRE_N) ? ((i == 2) ? 0 : 1) : 0);
            chk("b2b.done2_lo", done_b, 0);
            tick();
        end
        chk("b2b.done2", done_b, 1);
        chk("b2b.end_vld", dout_valid_b, 0);
        tick();
        chk("b2b.done2_once", done_b, 0);
        chk("b2b.idle_vld", dout_valid_b, 0);

        // Reset during data bit 4 of 81
        din = 8'h81;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < PRE_N + 3; i++) tick();
        chk("mid.vld_before", dout_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid.dout", dout, 0);
        chk("mid.vld", dout_valid, 0);
        chk("mid.busy", busy, 0);
        chk("mid.rdy", din_ready, 0);
        chk("mid.done", done, 0);
        tick();
        chk("mid.hold_vld", dout_valid, 0);
        rst = 1'b1;
        #1;
        chk("mid.rel_rdy", din_ready, 1);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("mid.no_done", done, 0);
            chk("mid.no_vld", dout_valid, 0);
        end
        run_frame(8'h81, 1'b0, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial frame transmitter that drives the single-bit `din` stream consumed by the team's Mealy overlapping sequence detectors. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock. The frame is followed by a programmable idle gap. An optional 1101 preamble can be prepended so that a downstream "1101" detector flags the start of each frame.

## Interface
- `WIDTH`, 8: data bits per frame, 2..32.
- `GAP_CYCLES`, 2: idle cycles after each frame, 0..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word to transmit.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial bit, forced to 0 whenever `dout_valid`=0.
- `dout_valid`  out  1  `dout` carries a frame bit.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the cycle after the last data bit.

## Operation
- States: IDLE, PRE (macro only), DATA, GAP.
- **IDLE**
  - `din_ready`=1.
  - When `din_valid`&&`din_ready` at a clock edge, `din` is captured into the shift register and a bit counter is loaded.
  - The next state is PRE if the macro is defined, otherwise DATA.
- **PRE**: emits 1,1,0,1 in four cycles with `dout_valid`=1, then moves to DATA.
- **DATA**
  - Emits `din[WIDTH-1]` down to `din[0]`, with `dout_valid`=1.
  - After bit 0 the block goes to GAP, or to IDLE if `GAP_CYCLES`=0.
- **GAP**
  - Holds for exactly `GAP_CYCLES` cycles with `dout`=0 and `dout_valid`=0, then returns to IDLE.
  - The gap counter is $clog2(16) bits wide and counts down to 0.
- `done` is high in the first cycle after the last DATA bit, whichever state that cycle falls in.
- `din_valid` and `din` are ignored outside IDLE. A word held on `din` during a frame is not lost; it is accepted on return to IDLE.
- Bit counter width is $clog2(WIDTH+1). It must not wrap; DATA length is exactly WIDTH cycles.
- Reset asserted mid-frame:
  - All state clears immediately (asynchronous) and the frame is dropped.
  - `done` does not pulse.
  - The first cycle after deassertion is IDLE.
- Reset values: `din_ready`=0 while `rst`=0 and 1 after release; `dout`=0, `dout_valid`=0, `busy`=0, `done`=0.

## Timing
- Accept edge T: the first frame bit appears on `dout` in cycle T+1 (registered output; no combinational path from `din` to `dout`).
- Frame length with `dout_valid`=1: WIDTH cycles, or WIDTH+4 with the preamble.
- `din_ready` drops in the cycle after acceptance and rises again WIDTH(+4)+`GAP_CYCLES` cycles later.
- Minimum spacing between accepted words: 1+WIDTH(+4)+`GAP_CYCLES` cycles.
- With `GAP_CYCLES`=0, `done` and `din_ready` are high in the same cycle. A word accepted there starts after exactly one cycle with `dout_valid`=0.
- `busy` equals the inverse of `din_ready` outside reset.

## Configuration
- Macro: `SEQ_PATTERN_TX_PREAMBLE_EN`.
- **Defined**: the PRE state exists and every frame starts with 1101. A downstream overlapping 1101 Mealy detector asserts its output on the fourth preamble bit.
- **Undefined**:
  - PRE state and its logic are absent.
  - Frames are raw data only.
  - Latency and frame length drop by 4.

## Structure
- Package `seq_tx_pkg` holds:
  - the state enum `seq_tx_state_t` (IDLE, PRE, DATA, GAP);
  - `SEQ_TX_PREAMBLE` = 4'b1101;
  - `SEQ_TX_PRE_LEN` = 4.
- Sub-module `seq_tx_shreg` is a loadable MSB-first WIDTH-bit shift register with load/shift enables and async active-low clear. The FSM, counters and handshake stay in the top.

## Test plan
Defaults are `WIDTH`=8 and `GAP_CYCLES`=2 unless stated.
- Reset: hold `rst`=0 for 2 cycles with `din_valid`=1. All outputs are 0. After release `din_ready`=1 and nothing is accepted before the first edge with `rst`=1.
- Single frame, macro off: send 8'hA5 with `din_valid` for one cycle. `dout` = 1,0,1,0,0,1,0,1 on cycles T+1..T+8 with `dout_valid`=1. `done` is high at T+9, and `din_ready` returns at T+11.
- Preamble, macro on: send 8'h3C. `dout` = 1,1,0,1,0,0,1,1,1,1,0,0 with `dout_valid`=1 for 12 cycles. A connected `mealyol` asserts `dout` on the fourth bit.
- Back-to-back with `GAP_CYCLES`=0: hold `din_valid`=1 with 8'hFF then 8'h00. Exactly one invalid cycle separates the frames, and `done` pulses once per frame.
- Mid-frame reset: pull `rst` low during bit 4 of 8'h81. Outputs are 0 immediately and `done` never pulses. After release, a new 8'h81 transmits in full.
- Ignored input: toggle `din` and `din_valid` during DATA. The transmitted bits match the originally captured word.
